// File: rtl/fetch_pair_unit.sv
// rtl/fetch_pair_unit.sv - fetch stage issuing 64-bit line reads and pushing two instruction slots per line
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   redirect_valid/_pc     single-cycle branch redirect from the backend
//   imem_addr/imem_rmask   8-byte aligned read request (rmask=4'hF for one cycle)
//   imem_rdata/imem_resp   read line and its response strobe
//   iq_full                instruction queue full
//   iq_push/iq_in[2]       2-wide queue push: {valid, pc, instruction} per slot
//   fetch_pc               current fetch pc (debug)
module fetch_pair_unit #(
    parameter logic [31:0] RESET_PC    = 32'h1eceb000,
    parameter int          ENTRY_WIDTH = 65
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            imem_addr,
    output logic [3:0]             imem_rmask,
    input  logic [63:0]            imem_rdata,
    input  logic                   imem_resp,
    input  logic                   iq_full,
    output logic                   iq_push,
    output logic [ENTRY_WIDTH-1:0] iq_in [2],
    output logic [31:0]            fetch_pc
);

    typedef enum logic [1:0] {ISSUE, WAIT, STALL, DISCARD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [63:0] hold_data;

    logic        push_en;
    logic [63:0] push_data;
    logic [31:0] base;

    assign base     = req_pc & 32'hffff_fff8;
    assign fetch_pc = pc;

    // Redirect always wins over a push, so every push condition excludes it.
    always_comb begin
        push_en   = 1'b0;
        push_data = imem_rdata;
        case (state)
            WAIT:    push_en = !redirect_valid && imem_resp && !iq_full;
            STALL: begin
                push_en   = !redirect_valid && !iq_full;
                push_data = hold_data;
            end
            default: push_en = 1'b0;
        endcase
    end

    always_comb begin
        iq_push = rst_n && push_en;
        iq_in[0] = '0;
        iq_in[1] = '0;
        if (iq_push) begin
            // A target at pc[2]=1 leaves the low half of the line unwanted.
            iq_in[0] = {~req_pc[2], base, push_data[31:0]};
            iq_in[1] = {1'b1, base + 32'd4, push_data[63:32]};
        end
    end

    always_comb begin
        imem_addr  = '0;
        imem_rmask = 4'h0;
        if (state == ISSUE) begin
            imem_addr = pc & 32'hffff_fff8;
            if (rst_n && !redirect_valid)
                imem_rmask = 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ISSUE;
            pc        <= RESET_PC;
            req_pc    <= '0;
            hold_data <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else begin
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        // Without the response in hand, the line still in flight must be dropped later.
                        state <= imem_resp ? ISSUE : DISCARD;
                    end else if (imem_resp) begin
                        if (!iq_full) begin
                            pc    <= base + 32'd8;
                            state <= ISSUE;
                        end else begin
                            hold_data <= imem_rdata;
                            state     <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= ISSUE;
                    end else if (!iq_full) begin
                        pc    <= base + 32'd8;
                        state <= ISSUE;
                    end
                end
                DISCARD: begin
                    if (redirect_valid)
                        pc <= redirect_pc;
                    if (imem_resp)
                        state <= ISSUE;
                end
                default: state <= ISSUE;
            endcase
        end
    end

    // A response may only arrive while a request is outstanding.
    resp_only_when_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_resp && (state == ISSUE || state == STALL)));

endmodule

// File: tb/tb_fetch_pair_unit.sv
// tb/tb_fetch_pair_unit.sv - directed cycle-vector bench for fetch_pair_unit
module tb_fetch_pair_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [63:0] imem_rdata;
    logic        imem_resp;
    logic        iq_full;
    logic        iq_push;
    logic [64:0] iq_in [2];
    logic [31:0] fetch_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_pair_unit #(.RESET_PC(32'h1eceb000), .ENTRY_WIDTH(65)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .iq_full(iq_full), .iq_push(iq_push), .iq_in(iq_in),
        .fetch_pc(fetch_pc)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        resp;
        logic [63:0] rd;
        logic        full;
        logic [31:0] ea;
        logic [3:0]  em;
        logic        ep;
        logic [64:0] es0;
        logic [64:0] es1;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic resp,
                                input logic [63:0] rd, input logic full, input logic [31:0] ea,
                                input logic [3:0] em, input logic ep, input logic [64:0] es0,
                                input logic [64:0] es1, input logic [31:0] epc);
        vec_t v;
        v.rst = 1'b1; v.rv = rv; v.rpc = rpc; v.resp = resp; v.rd = rd; v.full = full;
        v.ea = ea; v.em = em; v.ep = ep; v.es0 = es0; v.es1 = es1; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle, advance one edge.
    task automatic apply(input vec_t v, input string nm);
        rst_n          = v.rst;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        imem_resp      = v.resp;
        imem_rdata     = v.rd;
        iq_full        = v.full;
        @(negedge clk);
        chk({nm, ".addr"},  {33'd0, imem_addr},  {33'd0, v.ea});
        chk({nm, ".rmask"}, {61'd0, imem_rmask}, {61'd0, v.em});
        chk({nm, ".push"},  {64'd0, iq_push},    {64'd0, v.ep});
        chk({nm, ".slot0"}, iq_in[0], v.es0);
        chk({nm, ".slot1"}, iq_in[1], v.es1);
        chk({nm, ".pc"},    {33'd0, fetch_pc},   {33'd0, v.epc});
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] DA = 64'hAAAA0001_BBBB0002;
    localparam logic [63:0] DB = 64'hCAFE0004_DEAD0003;
    localparam logic [63:0] DC = 64'h0123456789abcdef;
    localparam logic [63:0] DG = 64'h5555666677778888;
    localparam logic [64:0] Z  = 65'd0;

    initial begin
        vec_t v;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_resp = 1'b0; imem_rdata = '0; iq_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset.pc",    {33'd0, fetch_pc},   {33'd0, 32'h1eceb000});
        chk("reset.rmask", {61'd0, imem_rmask}, 65'd0);
        chk("reset.push",  {64'd0, iq_push},    65'd0);
        chk("reset.slot0", iq_in[0], Z);
        @(posedge clk);
        #1;

        //              rv   rpc           resp rd  full ea            em    ep   slot0                                  slot1                                  pc
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h1eceb000, 4'hF, 0, Z, Z, 32'h1eceb000));
        tbl.push_back(mk(0, 32'h0,        1, DA,    0, 32'h0,        4'h0, 1, {1'b1, 32'h1eceb000, 32'hBBBB0002}, {1'b1, 32'h1eceb004, 32'hAAAA0001}, 32'h1eceb000));
        tbl.push_back(mk(1, 32'h1eceb104, 0, 64'h0, 0, 32'h1eceb008, 4'h0, 0, Z, Z, 32'h1eceb008));
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h1eceb100, 4'hF, 0, Z, Z, 32'h1eceb104));
        tbl.push_back(mk(0, 32'h0,        1, DB,    0, 32'h0,        4'h0, 1, {1'b0, 32'h1eceb100, 32'hDEAD0003}, {1'b1, 32'h1eceb104, 32'hCAFE0004}, 32'h1eceb104));
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h1eceb108, 4'hF, 0, Z, Z, 32'h1eceb108));
        tbl.push_back(mk(1, 32'h1eceb200, 0, 64'h0, 0, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb108));
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb200));
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb200));
        tbl.push_back(mk(0, 32'h0,        1, DA,    0, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb200));
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h1eceb200, 4'hF, 0, Z, Z, 32'h1eceb200));
        tbl.push_back(mk(1, 32'h1eceb300, 1, DB,    0, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb200));
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h1eceb300, 4'hF, 0, Z, Z, 32'h1eceb300));
        tbl.push_back(mk(0, 32'h0,        1, DA,    1, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb300));
        tbl.push_back(mk(1, 32'h1eceb400, 0, 64'h0, 1, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb300));
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h1eceb400, 4'hF, 0, Z, Z, 32'h1eceb400));
        tbl.push_back(mk(1, 32'h1eceb500, 0, 64'h0, 0, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb400));
        tbl.push_back(mk(1, 32'h1eceb600, 0, 64'h0, 0, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb500));
        tbl.push_back(mk(1, 32'h1eceb700, 1, DB,    0, 32'h0,        4'h0, 0, Z, Z, 32'h1eceb600));
        tbl.push_back(mk(0, 32'h0,        0, 64'h0, 0, 32'h1eceb700, 4'hF, 0, Z, Z, 32'h1eceb700));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // Response lands while the queue is full for five cycles, then drains.
        apply(mk(0, 32'h0, 1, DC, 1, 32'h0, 4'h0, 0, Z, Z, 32'h1eceb700), "stall.resp");
        for (int i = 0; i < 4; i++)
            apply(mk(0, 32'h0, 0, 64'h0, 1, 32'h0, 4'h0, 0, Z, Z, 32'h1eceb700), $sformatf("stall.hold%0d", i));
        apply(mk(0, 32'h0, 0, 64'h0, 0, 32'h0, 4'h0, 1, {1'b1, 32'h1eceb700, 32'h89abcdef},
                 {1'b1, 32'h1eceb704, 32'h01234567}, 32'h1eceb700), "stall.drain");
        apply(mk(0, 32'h0, 0, 64'h0, 0, 32'h1eceb708, 4'hF, 0, Z, Z, 32'h1eceb708), "stall.next");

        // Wrap of the pc past 2^32, then a reset while a request is outstanding.
        apply(mk(1, 32'hfffffff8, 1, DA, 0, 32'h0, 4'h0, 0, Z, Z, 32'h1eceb708), "wrap.redir");
        apply(mk(0, 32'h0, 0, 64'h0, 0, 32'hfffffff8, 4'hF, 0, Z, Z, 32'hfffffff8), "wrap.issue");
        apply(mk(0, 32'h0, 1, DG, 0, 32'h0, 4'h0, 1, {1'b1, 32'hfffffff8, 32'h77778888},
                 {1'b1, 32'hfffffffc, 32'h55556666}, 32'hfffffff8), "wrap.push");
        apply(mk(0, 32'h0, 0, 64'h0, 0, 32'h0, 4'hF, 0, Z, Z, 32'h0), "wrap.next");
        v = mk(0, 32'h0, 0, 64'h0, 0, 32'h0, 4'h0, 0, Z, Z, 32'h0);
        v.rst = 1'b0;
        apply(v, "rst.wait");
        apply(mk(0, 32'h0, 0, 64'h0, 0, 32'h1eceb000, 4'hF, 0, Z, Z, 32'h1eceb000), "rst.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
